pwm_multichannel: RTL

- Parametrised successor to the fixed 16-channel, 8-bit PWM peripheral.
- Generates NUM_CH independent PWM outputs that share one timebase.
- Adds:
  - configurable counter width;
  - clock prescaler;
  - programmable period;
  - edge-aligned or center-aligned mode;
  - double-buffered (shadowed) duty/period updates that take effect only at a period boundary.
- Sits between the SPI register file and the top-level output pins.

---
 rtl/pwm_multichannel.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multichannel
//  Description : NUM_CH PWM outputs sharing one prescaled timebase, with
//                edge/center-aligned counting and shadowed duty/period/
//                prescale/mode registers that reload only at a period
//                boundary.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module pwm_multichannel #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en_out,
    input  logic [NUM_CH-1:0]         en_pwm,
    input  logic [NUM_CH*CNT_W-1:0]   duty,
    input  logic [CNT_W-1:0]          period,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic                      mode,
    input  logic                      commit,
    output logic [NUM_CH-1:0]         out,
    output logic                      period_start,
    output logic                      busy
);

    localparam logic             c_DIR_UP   = 1'b0;
    localparam logic             c_DIR_DOWN = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [PRESC_W-1:0] c_PRESC_ONE = PRESC_W'(1);

    // Timebase state
    logic [PRESC_W-1:0]       r_presc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_dir;
    logic                     r_pending;
    logic                     r_bnd_d;
    logic                     r_period_start;
    logic [NUM_CH-1:0]        r_out;

    // Shadow copies of the programmable inputs
    logic [NUM_CH*CNT_W-1:0]  r_duty_s;
    logic [CNT_W-1:0]         r_period_s;
    logic [PRESC_W-1:0]       r_presc_s;
    logic                     r_mode_s;

    logic                     w_tick;
    logic                     w_wrap;
    logic                     w_boundary;
    logic                     w_load;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_dir_nxt;
    logic [NUM_CH-1:0]        w_pwm;

    assign w_tick     = (r_presc == r_presc_s);
    assign w_boundary = w_tick & w_wrap;
    // A commit arriving on the boundary cycle itself is honoured immediately.
    assign w_load     = w_boundary & (r_pending | commit);

    // Next counter value/direction and whether this step returns to zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_wrap    = 1'b0;
        if (!r_mode_s) begin
            if (r_cnt >= r_period_s) w_wrap = 1'b1;
            else                     w_cnt_nxt = r_cnt + c_CNT_ONE;
        end else if (r_dir == c_DIR_UP) begin
            if (r_cnt >= r_period_s) begin
                // P<=1 has no down-slope: the top value falls straight to 0.
                if (r_period_s <= c_CNT_ONE) begin
                    w_wrap = 1'b1;
                end else begin
                    w_cnt_nxt = r_period_s - c_CNT_ONE;
                    w_dir_nxt = c_DIR_DOWN;
                end
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end else begin
            if (r_cnt <= c_CNT_ONE) w_wrap = 1'b1;
            else                    w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
        if (w_wrap) begin
            w_cnt_nxt = '0;
            w_dir_nxt = c_DIR_UP;
        end
    end

    // Prescaler, counter and direction advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_dir   <= c_DIR_UP;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end else begin
            r_presc <= r_presc + c_PRESC_ONE;
        end
    end

    // Commit bookkeeping and shadow reload at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 1'b0;
            r_duty_s   <= '0;
            r_period_s <= '0;
            r_presc_s  <= '0;
            r_mode_s   <= 1'b0;
        end else begin
            if (w_boundary)  r_pending <= 1'b0;
            else if (commit) r_pending <= 1'b1;
            if (w_load) begin
                r_duty_s   <= duty;
                r_period_s <= period;
                r_presc_s  <= prescale;
                r_mode_s   <= mode;
            end
        end
    end

    // Per-channel raw compare against the shared counter.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_pwm[i] = (r_cnt < r_duty_s[i*CNT_W +: CNT_W]);
    end

    // Registered outputs; period_start is delayed twice so it lines up with
    // the first output sample of the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out          <= '0;
            r_bnd_d        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_out          <= en_out & (~en_pwm | w_pwm);
            r_bnd_d        <= w_boundary;
            r_period_start <= r_bnd_d;
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;
    assign busy         = r_pending;

endmodule
`default_nettype wire
